// File: rtl/axis_interp_upsampler_pkg.sv
// Shared types and width helpers for the linear-interpolating AXI-Stream upsampler.
package axis_interp_upsampler_pkg;

   typedef enum logic [1:0] {EMPTY, HOLD, RAMP} state_t;

   // Accumulator carries the sample scaled by 2^L plus one guard bit.
   function automatic int unsigned acc_width(input int unsigned saxis_w, input int unsigned interp_l);
      return saxis_w + interp_l + 1;
   endfunction

   // Segment delta must hold max-min without wrapping.
   function automatic int unsigned delta_width(input int unsigned saxis_w);
      return saxis_w + 1;
   endfunction

endpackage

// File: rtl/axis_skid1.sv
// One-deep input holding register; tready is registered as the inverse of the next pend_valid.
module axis_skid1 #(
   parameter int unsigned W = 32
) (
   input  logic                a_clk,
   input  logic                reset,
   input  logic                flush,
   input  logic signed [W-1:0] s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   input  logic                consume,
   output logic signed [W-1:0] pend,
   output logic                pend_valid
);

   logic accept_c;
   logic pend_valid_nxt_c;

   always_comb begin
      accept_c         = s_tvalid && s_tready;
      pend_valid_nxt_c = pend_valid;
      if (accept_c)
         pend_valid_nxt_c = 1'b1;
      else if (consume)
         pend_valid_nxt_c = 1'b0;
   end

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         s_tready   <= 1'b0;
      end else if (flush) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         s_tready   <= 1'b0;
      end else begin
         if (accept_c)
            pend <= s_tdata;
         pend_valid <= pend_valid_nxt_c;
         s_tready   <= !pend_valid_nxt_c;
      end
   end

endmodule

// File: rtl/axis_interp_upsampler.sv
// Slow-rate AXI-Stream samples in, one linearly interpolated sample per next_dv strobe out;
// each segment ramps from the previous target to the new one in exactly 2^INTERP_L strobes.
module axis_interp_upsampler
   import axis_interp_upsampler_pkg::*;
#(
   parameter int unsigned SAXIS_TDATA_WIDTH = 32,
   parameter int unsigned MAXIS_TDATA_WIDTH = 32,
   parameter int unsigned INTERP_L          = 6
) (
   input  logic                                a_clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                next_dv,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                                S_AXIS_tvalid,
   output logic                                S_AXIS_tready,
   output logic        [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
   output logic                                M_AXIS_tvalid,
   output logic                                underrun,
   output logic        [31:0]                  seg_count
);

   localparam int unsigned ACC_W   = acc_width(SAXIS_TDATA_WIDTH, INTERP_L);
   localparam int unsigned DELTA_W = delta_width(SAXIS_TDATA_WIDTH);
   localparam int unsigned K_W     = INTERP_L + 1;
   localparam int unsigned OUT_MSB = SAXIS_TDATA_WIDTH + INTERP_L - 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(2 ** INTERP_L);

   state_t                       state;
   logic signed [SAXIS_TDATA_WIDTH-1:0] target;
   logic signed [SAXIS_TDATA_WIDTH-1:0] pend;
   logic                         pend_valid;
   logic signed [DELTA_W-1:0]    delta;
   logic signed [DELTA_W-1:0]    delta_new_c;
   logic signed [ACC_W-1:0]      acc;
   logic        [K_W-1:0]        k;
   logic                         seg_end_c;
   logic                         load_c;

   axis_skid1 #(.W(SAXIS_TDATA_WIDTH)) u_skid (
      .a_clk      (a_clk),
      .reset      (reset),
      .flush      (!enable),
      .s_tdata    (S_AXIS_tdata),
      .s_tvalid   (S_AXIS_tvalid),
      .s_tready   (S_AXIS_tready),
      .consume    (load_c),
      .pend       (pend),
      .pend_valid (pend_valid)
   );

   // A pending sample is taken on entry from EMPTY, or at a strobe in HOLD / at a finished segment.
   always_comb begin
      seg_end_c   = (state == RAMP) && (k == K_LAST);
      delta_new_c = DELTA_W'(pend) - DELTA_W'(target);
      load_c      = enable && pend_valid &&
                    ((state == EMPTY) || (next_dv && ((state == HOLD) || seg_end_c)));
   end

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         state         <= EMPTY;
         target        <= '0;
         delta         <= '0;
         acc           <= '0;
         k             <= '0;
         M_AXIS_tdata  <= '0;
         M_AXIS_tvalid <= 1'b0;
         underrun      <= 1'b0;
         seg_count     <= '0;
      end else if (!enable) begin
         state         <= EMPTY;
         target        <= '0;
         delta         <= '0;
         acc           <= '0;
         k             <= '0;
         M_AXIS_tdata  <= '0;
         M_AXIS_tvalid <= 1'b0;
         underrun      <= 1'b0;
         seg_count     <= '0;
      end else begin
         underrun     <= 1'b0;
         M_AXIS_tdata <= acc[OUT_MSB -: MAXIS_TDATA_WIDTH];
         case (state)
            EMPTY: begin
               if (pend_valid) begin
                  target        <= pend;
                  acc           <= ACC_W'(pend) <<< INTERP_L;
                  state         <= HOLD;
                  M_AXIS_tvalid <= 1'b1;
               end
            end
            HOLD: begin
               if (load_c) begin
                  delta  <= delta_new_c;
                  target <= pend;
                  acc    <= acc + ACC_W'(delta_new_c);
                  k      <= K_W'(1);
                  state  <= RAMP;
               end
            end
            RAMP: begin
               if (next_dv) begin
                  if (seg_end_c) begin
                     if (load_c) begin
                        delta  <= delta_new_c;
                        target <= pend;
                        acc    <= acc + ACC_W'(delta_new_c);
                        k      <= K_W'(1);
                     end else begin
                        underrun <= 1'b1;
                        state    <= HOLD;
                     end
                  end else begin
                     acc <= acc + ACC_W'(delta);
                     k   <= k + K_W'(1);
                     if (k == K_LAST - K_W'(1))
                        seg_count <= seg_count + 32'd1;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_interp_upsampler.sv
// Directed scoreboard bench for axis_interp_upsampler with INTERP_L=2 (four strobes per segment).
module tb_axis_interp_upsampler;

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] val;
   } exp_t;

   logic               a_clk = 1'b0;
   logic               reset;
   logic               enable;
   logic               next_dv;
   logic signed [31:0] S_AXIS_tdata;
   logic               S_AXIS_tvalid;
   logic               S_AXIS_tready;
   logic        [31:0] M_AXIS_tdata;
   logic               M_AXIS_tvalid;
   logic               underrun;
   logic        [31:0] seg_count;

   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc   = 0;
   int   n_under = 0;
   exp_t q[$];

   localparam int MAXV = 2147483647;
   localparam int MINV = int'(32'h8000_0000);

   axis_interp_upsampler #(
      .SAXIS_TDATA_WIDTH (32),
      .MAXIS_TDATA_WIDTH (32),
      .INTERP_L          (2)
   ) dut (
      .a_clk         (a_clk),
      .reset         (reset),
      .enable        (enable),
      .next_dv       (next_dv),
      .S_AXIS_tdata  (S_AXIS_tdata),
      .S_AXIS_tvalid (S_AXIS_tvalid),
      .S_AXIS_tready (S_AXIS_tready),
      .M_AXIS_tdata  (M_AXIS_tdata),
      .M_AXIS_tvalid (M_AXIS_tvalid),
      .underrun      (underrun),
      .seg_count     (seg_count)
   );

   always #5 a_clk = ~a_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Linear interpolation reference: step j of the segment prev -> cur, output = acc >> L.
   function automatic logic [31:0] interp(input int prev, input int cur, input int j);
      longint a;
      a = (longint'(prev) <<< 2) + longint'(j) * (longint'(cur) - longint'(prev));
      return 32'(a >>> 2);
   endfunction

   task automatic tick();
      exp_t e;
      @(posedge a_clk);
      #1;
      cyc++;
      if (underrun === 1'b1) n_under++;
      while (q.size() > 0 && int'(q[0].due) <= cyc) begin
         e = q.pop_front();
         chk("tdata", M_AXIS_tdata, e.val);
      end
   endtask

   task automatic strobe(input logic [31:0] e);
      exp_t x;
      next_dv = 1'b1;
      x.due = 32'(cyc + 2);
      x.val = e;
      q.push_back(x);
      tick();
      next_dv = 1'b0;
   endtask

   task automatic send(input int s);
      bit ok;
      ok = 1'b0;
      S_AXIS_tdata  = s;
      S_AXIS_tvalid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (S_AXIS_tready === 1'b1) ok = 1'b1;
         tick();
      end
      S_AXIS_tvalid = 1'b0;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   initial begin
      int  smp [7];
      int  idx;
      int  prv;
      bit  acc_now;

      smp = '{1000, -2000, 3000, 7, -5, 42, 0};
      reset = 1'b1; enable = 1'b1; next_dv = 1'b0;
      S_AXIS_tdata = '0; S_AXIS_tvalid = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_tdata", M_AXIS_tdata, 32'd0);
      chk("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      chk("rst_tready", 32'(S_AXIS_tready), 32'd0);
      chk("rst_under", 32'(underrun), 32'd0);
      chk("rst_seg", seg_count, 32'd0);
      reset = 1'b0;
      tick();
      chk("tready_idle", 32'(S_AXIS_tready), 32'd1);

      // Basic ramp 0 -> 400, then hold with one underrun
      send(0);
      send(400);
      chk("hold_tvalid", 32'(M_AXIS_tvalid), 32'd1);
      chk("hold_tdata", M_AXIS_tdata, 32'd0);
      chk("hold_tready", 32'(S_AXIS_tready), 32'd0);
      for (int j = 1; j <= 16; j++)
         strobe(j <= 4 ? interp(0, 400, j) : 32'd400);
      tick(); tick();
      chk("t1_under", 32'(n_under), 32'd1);
      chk("t1_seg", seg_count, 32'd1);

      // Samples queued during active ramps chain with no gap strobe
      send(1200);
      strobe(interp(400, 1200, 1));
      send(400);
      chk("t2_tready_full_a", 32'(S_AXIS_tready), 32'd0);
      for (int j = 2; j <= 4; j++) strobe(interp(400, 1200, j));
      chk("t2_seg_a", seg_count, 32'd2);
      strobe(interp(1200, 400, 1));
      send(-400);
      chk("t2_tready_full_b", 32'(S_AXIS_tready), 32'd0);
      for (int j = 2; j <= 4; j++) strobe(interp(1200, 400, j));
      for (int j = 1; j <= 4; j++) strobe(interp(400, -400, j));
      strobe(-400);
      tick(); tick();
      chk("t2_under", 32'(n_under), 32'd2);
      chk("t2_seg", seg_count, 32'd4);

      // Full-scale spans
      send(MAXV);
      for (int j = 1; j <= 4; j++) strobe(interp(-400, MAXV, j));
      strobe(MAXV);
      send(MINV);
      for (int j = 1; j <= 4; j++) strobe(interp(MAXV, MINV, j));
      strobe(MINV);
      tick(); tick();
      chk("t3_final", M_AXIS_tdata, 32'h8000_0000);
      chk("t3_under", 32'(n_under), 32'd4);
      chk("t3_seg", seg_count, 32'd6);

      // tvalid held high, strobe every cycle: back-to-back segments
      send(smp[0]);
      idx = 1;
      S_AXIS_tdata  = smp[idx];
      S_AXIS_tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         acc_now = S_AXIS_tready;
         prv = (i / 4 == 0) ? MINV : smp[i / 4 - 1];
         strobe(interp(prv, smp[i / 4], i % 4 + 1));
         if (acc_now) begin
            idx++;
            if (idx < 6) S_AXIS_tdata = smp[idx];
            else S_AXIS_tvalid = 1'b0;
         end
         if (i % 4 == 3) chk("t4_seg", seg_count, 32'(7 + i / 4));
      end
      S_AXIS_tvalid = 1'b0;
      tick(); tick();
      chk("t4_under", 32'(n_under), 32'd4);

      // Async reset mid-ramp at k=2
      strobe(interp(-5, 42, 1));
      strobe(interp(-5, 42, 2));
      tick();
      reset = 1'b1;
      #1;
      chk("arst_tdata", M_AXIS_tdata, 32'd0);
      chk("arst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      chk("arst_tready", 32'(S_AXIS_tready), 32'd0);
      chk("arst_seg", seg_count, 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      send(77);
      chk("arst_empty_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      tick(); tick();
      chk("arst_hold_tvalid", 32'(M_AXIS_tvalid), 32'd1);
      chk("arst_hold_tdata", M_AXIS_tdata, 32'd77);

      // One-cycle flush during a ramp with a pending sample
      send(177);
      strobe(interp(77, 177, 1));
      send(500);
      strobe(interp(77, 177, 2));
      tick();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      chk("flush_tvalid", 32'(M_AXIS_tvalid), 32'd0);
      chk("flush_tdata", M_AXIS_tdata, 32'd0);
      chk("flush_tready", 32'(S_AXIS_tready), 32'd0);
      chk("flush_seg", seg_count, 32'd0);
      tick(); tick(); tick();
      chk("flush_pend_drop", 32'(M_AXIS_tvalid), 32'd0);
      chk("flush_tready_up", 32'(S_AXIS_tready), 32'd1);
      chk("flush_tdata_zero", M_AXIS_tdata, 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/axis_interp_upsampler.md
Name: axis_interp_upsampler

Overview:
- Counterpart to the moving-average decimator. Accepts slow-rate signed samples on an AXI-Stream slave with backpressure.
- Emits one linearly interpolated sample per `next_dv` strobe. The output ramps from the previous sample to the current one in exactly 2^INTERP_L strobes.
- Sits between slow controller/DSP output streams and the fast a_clk-rate DAC/feedback path.

Parameters:
- SAXIS_TDATA_WIDTH, 32, signed input sample width.
- MAXIS_TDATA_WIDTH, 32, output width. Must be ≤ SAXIS_TDATA_WIDTH+INTERP_L. Output is the top MAXIS bits of the accumulator.
- INTERP_L, 6, log2 of interpolation factor N (N = 2^INTERP_L strobes per segment).

Ports:
- a_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  synchronous flush when low: behaves as reset, except that reset is asynchronous.
- next_dv  in  1  output-rate strobe; one interpolation step per high cycle.
- S_AXIS_tdata  in  SAXIS_TDATA_WIDTH  signed input sample.
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  input ready.
- M_AXIS_tdata  out  MAXIS_TDATA_WIDTH  interpolated output.
- M_AXIS_tvalid  out  1  output valid.
- underrun  out  1  one-cycle pulse when a segment ends with no pending sample.
- seg_count  out  32  number of completed segments, wrapping.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-high.
- Reset or enable=0 sets:
  - state=EMPTY, pend_valid=0, acc=0, k=0.
  - M_AXIS_tdata=0, M_AXIS_tvalid=0, S_AXIS_tready=0 while in reset, underrun=0, seg_count=0.
- Reset mid-ramp abandons the ramp; no partial state survives.
- Storage:
  - target, signed SAXIS bits.
  - delta = new − target, signed SAXIS+1 bits.
  - acc, signed SAXIS+INTERP_L+1 bits.
  - k, INTERP_L+1 bits.
  - pend (sample) plus pend_valid, forming a one-deep skid.
- S_AXIS_tready = !pend_valid, purely registered, with no combinational path from next_dv.
- A transfer occurs on tvalid&&tready and sets pend <= tdata, pend_valid <= 1.
- States:
  - EMPTY:
    - Pending sample is consumed immediately, without waiting for next_dv: target <= pend, acc <= pend<<INTERP_L, pend_valid <= 0, go to HOLD.
    - M_AXIS_tvalid rises in the same cycle the state enters HOLD.
  - HOLD (on next_dv):
    - If pend_valid: delta <= pend−target, target <= pend, acc <= acc+delta, k <= 1, pend_valid <= 0, go to RAMP.
    - Otherwise acc holds; no underrun pulse in HOLD.
  - RAMP (on next_dv):
    - acc <= acc+delta, k <= k+1.
    - When the step makes k==N: acc equals target<<INTERP_L exactly; seg_count increments.
    - Following next_dv after k==N: if pend_valid, start the next segment exactly as in HOLD, with no gap. Otherwise underrun pulses and the state goes to HOLD.
- next_dv with no enable effect in EMPTY: ignored.
- An input accept and a segment load in the same cycle are legal. The load uses the old pend; the new sample cannot arrive that cycle because tready=0.
- M_AXIS_tdata <= acc[SAXIS+INTERP_L-1 : SAXIS+INTERP_L-MAXIS]. This is registered, giving 1-cycle latency after the acc update (2 cycles after the next_dv edge).
- Arithmetic: no saturation is needed, since acc stays between prev and target; acc is truncated safely.
- delta of the extreme span (max − min) needs SAXIS+1 bits and must not wrap.
- M_AXIS_tvalid stays high from the first HOLD until reset or flush.

Decomposition:
- Shared package holds:
  - the state enum {EMPTY, HOLD, RAMP};
  - width helper constants ACC_W = SAXIS+INTERP_L+1 and DELTA_W = SAXIS+1.
- One sub-module is natural: axis_skid1, the one-deep pend register with tready/tvalid. Keep the ramp datapath inline.

Test Plan (INTERP_L=2, N=4, 32/32 widths):
- Reset, then sample 0, then sample 400, then 16 next_dv strobes → outputs 0 (HOLD), 100, 200, 300, 400, then held at 400; underrun pulses once; seg_count=1.
- Samples 400, −400 queued during an active ramp → outputs 200, 0, −200, −400 with no gap strobe between segments; tready low while pend is full.
- Extremes 0x7FFFFFFF then 0x80000000 → monotonic descent with steps of −(2^32−1)/4, final exactly 0x80000000; no wrap.
- tvalid held high continuously with a strobe every cycle → segments chain back-to-back; seg_count increments every 4 strobes; underrun never pulses.
- Assert reset asynchronously mid-ramp (k=2) → all outputs go to 0 immediately with no clock; after release, first accepted sample re-enters via EMPTY.
- enable=0 for one cycle during RAMP with pend_valid=1 → pend dropped, tvalid drops next cycle, output returns to 0.
